// File: rtl/ascon_enc_out_serializer.sv
// Captures an encryption result on the rising edge of encryption_ready and streams it as
// W-bit words: ciphertext words first (MSB-first, zero-padded), then tag words.
module ascon_enc_out_serializer #(
    parameter int unsigned y = 40,
    parameter int unsigned W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [y-1:0]   cipher_text,
    input  logic [127:0]   tag,
    input  logic           encryption_ready,
    input  logic           out_ready,
    input  logic           clear_overrun,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic           out_is_tag,
    output logic           out_last,
    output logic           busy,
    output logic           overrun
);

    localparam int unsigned NCT  = (y + W - 1) / W;
    localparam int unsigned NTAG = 128 / W;
    localparam int unsigned CTW  = NCT * W;
    localparam int unsigned MAXW = (NCT > NTAG) ? NCT : NTAG;
    localparam int unsigned IDXW = (MAXW > 1) ? $clog2(MAXW) : 1;

    localparam logic [IDXW-1:0] CtLast  = IDXW'(NCT - 1);
    localparam logic [IDXW-1:0] TagLast = IDXW'(NTAG - 1);

    typedef enum logic [1:0] {StIdle, StCt, StTag} state_e;

    state_e            state;
    logic              er_q;
    logic [CTW-1:0]    ct_buf;
    logic [127:0]      tag_buf;
    logic [IDXW-1:0]   idx;

    logic              ev;
    logic              hs;
    logic              tag_done;
    logic              capture;
    logic              drop;
    logic [CTW-1:0]    cap_ct;
    logic [IDXW-1:0]   idx_inc;

    function automatic logic [W-1:0] ct_word(input logic [CTW-1:0] b,
                                             input logic [IDXW-1:0] i);
        logic [W-1:0] w;
        w = '0;
        for (int k = 0; k < int'(NCT); k++) begin
            if (i == IDXW'(k)) w = b[CTW-1-k*W -: W];
        end
        return w;
    endfunction

    function automatic logic [W-1:0] tag_word(input logic [127:0] b,
                                              input logic [IDXW-1:0] i);
        logic [W-1:0] w;
        w = '0;
        for (int k = 0; k < int'(NTAG); k++) begin
            if (i == IDXW'(k)) w = b[127-k*W -: W];
        end
        return w;
    endfunction

    always_comb begin
        ev       = encryption_ready & ~er_q;
        hs       = out_valid & out_ready;
        tag_done = (state == StTag) & hs & (idx == TagLast);
        // A result landing exactly on the final tag handshake chains straight into a new frame.
        capture  = ev & ((state == StIdle) | tag_done);
        drop     = ev & (state != StIdle) & ~tag_done;
        cap_ct   = CTW'(cipher_text) << (CTW - y);
        idx_inc  = idx + IDXW'(1);
    end

    assign busy = (state != StIdle);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= StIdle;
            er_q       <= 1'b0;
            ct_buf     <= '0;
            tag_buf    <= '0;
            idx        <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_is_tag <= 1'b0;
            out_last   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            er_q <= encryption_ready;

            if (drop) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end

            if (capture) begin
                ct_buf     <= cap_ct;
                tag_buf    <= tag;
                idx        <= '0;
                state      <= StCt;
                out_valid  <= 1'b1;
                out_is_tag <= 1'b0;
                out_last   <= 1'b0;
                out_data   <= ct_word(cap_ct, '0);
            end else begin
                unique case (state)
                    StCt: begin
                        if (hs) begin
                            if (idx == CtLast) begin
                                idx        <= '0;
                                state      <= StTag;
                                out_is_tag <= 1'b1;
                                out_last   <= (NTAG == 1);
                                out_data   <= tag_word(tag_buf, '0);
                            end else begin
                                idx      <= idx_inc;
                                out_data <= ct_word(ct_buf, idx_inc);
                            end
                        end
                    end
                    StTag: begin
                        if (hs) begin
                            if (idx == TagLast) begin
                                idx        <= '0;
                                state      <= StIdle;
                                out_valid  <= 1'b0;
                                out_is_tag <= 1'b0;
                                out_last   <= 1'b0;
                                out_data   <= '0;
                            end else begin
                                idx      <= idx_inc;
                                out_last <= (idx_inc == TagLast);
                                out_data <= tag_word(tag_buf, idx_inc);
                            end
                        end
                    end
                    default: begin
                        out_valid  <= 1'b0;
                        out_is_tag <= 1'b0;
                        out_last   <= 1'b0;
                        out_data   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ascon_enc_out_serializer.sv
// Scoreboard bench: stimulus pushes expected words, a negedge monitor checks what the DUT presents.
module tb_ascon_enc_out_serializer;

    localparam int unsigned Y = 40;
    localparam int unsigned WW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [Y-1:0]    cipher_text = '0;
    logic [127:0]    tag = '0;
    logic            encryption_ready = 1'b0;
    logic            out_ready = 1'b0;
    logic            clear_overrun = 1'b0;
    logic            out_valid;
    logic [WW-1:0]   out_data;
    logic            out_is_tag;
    logic            out_last;
    logic            busy;
    logic            overrun;

    int checks = 0;
    int errors = 0;
    int hs_count = 0;
    logic [WW+1:0] exp_q[$];

    ascon_enc_out_serializer #(.y(Y), .W(WW)) dut (
        .clk              (clk),
        .rst              (rst),
        .cipher_text      (cipher_text),
        .tag              (tag),
        .encryption_ready (encryption_ready),
        .out_ready        (out_ready),
        .clear_overrun    (clear_overrun),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_is_tag       (out_is_tag),
        .out_last         (out_last),
        .busy             (busy),
        .overrun          (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame A: ct 0123456789, tag 00112233_44556677_8899AABB_CCDDEEFF
    task automatic push_a();
        exp_q.push_back({1'b0, 1'b0, 32'h01234567});
        exp_q.push_back({1'b0, 1'b0, 32'h89000000});
        exp_q.push_back({1'b1, 1'b0, 32'h00112233});
        exp_q.push_back({1'b1, 1'b0, 32'h44556677});
        exp_q.push_back({1'b1, 1'b0, 32'h8899AABB});
        exp_q.push_back({1'b1, 1'b1, 32'hCCDDEEFF});
    endtask

    // Frame B: ct A1B2C3D4E5, tag FFEEDDCC_BBAA9988_77665544_33221100
    task automatic push_b();
        exp_q.push_back({1'b0, 1'b0, 32'hA1B2C3D4});
        exp_q.push_back({1'b0, 1'b0, 32'hE5000000});
        exp_q.push_back({1'b1, 1'b0, 32'hFFEEDDCC});
        exp_q.push_back({1'b1, 1'b0, 32'hBBAA9988});
        exp_q.push_back({1'b1, 1'b0, 32'h77665544});
        exp_q.push_back({1'b1, 1'b1, 32'h33221100});
    endtask

    task automatic drive_a();
        cipher_text = 40'h0123456789;
        tag = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    endtask

    task automatic drive_b();
        cipher_text = 40'hA1B2C3D4E5;
        tag = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        int n = 0;
        while (busy && n < max_cycles) begin
            tick();
            n++;
        end
        chk(name, {127'b0, busy}, 128'd0);
        chk({name, "_queue"}, exp_q.size(), 128'd0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%h required=none at %0t",
                             {out_is_tag, out_last, out_data}, $time);
                end else begin
                    chk("word", {94'b0, out_is_tag, out_last, out_data}, {94'b0, exp_q[0]});
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        hs_count++;
                    end
                end
            end else begin
                chk("idle_zero", {94'b0, out_is_tag, out_last, out_data}, 128'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        // Reset state
        #2 rst = 1'b0;
        #1;
        chk("rst_valid", {127'b0, out_valid}, 0);
        chk("rst_busy", {127'b0, busy}, 0);
        chk("rst_overrun", {127'b0, overrun}, 0);
        chk("rst_data", {96'b0, out_data}, 0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (2) tick();

        // Basic frame: latency and busy timing
        out_ready = 1'b1;
        drive_a();
        push_a();
        encryption_ready = 1'b1;
        #1 chk("no_comb_path", {127'b0, out_valid}, 0);
        tick();
        chk("latency_valid", {127'b0, out_valid}, 1);
        encryption_ready = 1'b0;
        repeat (5) tick();
        chk("last_word_busy", {127'b0, busy}, 1);
        chk("last_word_flag", {127'b0, out_last}, 1);
        tick();
        chk("busy_fall", {127'b0, busy}, 0);
        wait_idle("basic_drain", 10);

        // Backpressure 1,0,0,1,...
        drive_b();
        push_b();
        encryption_ready = 1'b1;
        tick();
        encryption_ready = 1'b0;
        for (int i = 0; i < 80 && busy; i++) begin
            out_ready = (i % 4 == 0) || (i % 4 == 3);
            tick();
        end
        out_ready = 1'b1;
        wait_idle("bp_drain", 10);

        // Overrun: drop while stalled, set wins over clear, clear afterwards
        out_ready = 1'b0;
        drive_a();
        push_a();
        encryption_ready = 1'b1;
        tick();
        encryption_ready = 1'b0;
        tick();
        drive_b();
        encryption_ready = 1'b1;
        tick();
        chk("overrun_set", {127'b0, overrun}, 1);
        encryption_ready = 1'b0;
        tick();
        encryption_ready = 1'b1;
        clear_overrun = 1'b1;
        tick();
        chk("overrun_set_wins", {127'b0, overrun}, 1);
        encryption_ready = 1'b0;
        clear_overrun = 1'b0;
        out_ready = 1'b1;
        wait_idle("overrun_drain", 20);
        chk("overrun_sticky", {127'b0, overrun}, 1);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        chk("overrun_clear", {127'b0, overrun}, 0);

        // Back-to-back: second edge on the final tag handshake
        drive_a();
        push_a();
        encryption_ready = 1'b1;
        tick();
        encryption_ready = 1'b0;
        repeat (5) tick();
        chk("b2b_on_last", {127'b0, out_last}, 1);
        drive_b();
        push_b();
        encryption_ready = 1'b1;
        tick();
        chk("b2b_valid", {127'b0, out_valid}, 1);
        chk("b2b_is_ct", {127'b0, out_is_tag}, 0);
        chk("b2b_no_overrun", {127'b0, overrun}, 0);
        encryption_ready = 1'b0;
        wait_idle("b2b_drain", 20);

        // Held level produces exactly one frame
        hs0 = hs_count;
        drive_a();
        push_a();
        encryption_ready = 1'b1;
        repeat (20) tick();
        encryption_ready = 1'b0;
        wait_idle("held_drain", 10);
        chk("held_count", hs_count - hs0, 6);
        chk("held_overrun", {127'b0, overrun}, 0);

        // Asynchronous reset mid-frame
        out_ready = 1'b0;
        drive_b();
        push_b();
        encryption_ready = 1'b1;
        tick();
        encryption_ready = 1'b0;
        tick();
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("arst_valid", {127'b0, out_valid}, 0);
        chk("arst_busy", {127'b0, busy}, 0);
        chk("arst_last", {127'b0, out_last}, 0);
        exp_q.delete();
        tick();
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (10) tick();
        chk("post_rst_idle", {127'b0, busy}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
